// File: rtl/clk_sched_pkg.sv
// Shared types and defaults for the scheduled clock divider.
// Imported by the top level; sub-modules take widths as parameters.
package clk_sched_pkg;

    localparam int CNT_W        = 16;
    localparam int DEFAULT_HALF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } state_t;

endpackage

// File: rtl/clk_sched_counter.sv
// Half-period counter and toggle flop for the divided clock.
// fall is combinational: high on the cycle whose edge drives clk_out 1->0.
module clk_sched_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] half,
    input  logic             run,
    output logic             clk_out,
    output logic             tick,
    output logic             fall
);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = run && (cnt == half - CNT_W'(1));
    assign fall = wrap && clk_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (!run) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            tick    <= ~clk_out;
        end else begin
            cnt     <= cnt + CNT_W'(1);
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Clock divider with glitch-free reconfiguration: changes made while
// running are deferred to the next falling edge of clk_out.
module clk_div_sched #(
    parameter int CNT_W        = clk_sched_pkg::CNT_W,
    parameter int DEFAULT_HALF = clk_sched_pkg::DEFAULT_HALF,
    parameter bit START_ON     = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic             cfg_enable,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    import clk_sched_pkg::*;

    state_t           state;
    logic [CNT_W-1:0] half_reg;
    logic [CNT_W-1:0] pend_half;
    logic [CNT_W-1:0] half_in;
    logic             pend_enable;
    logic             accept;
    logic             fall;

    assign accept  = cfg_valid && cfg_ready;
    assign half_in = (cfg_half == '0) ? CNT_W'(1) : cfg_half;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= START_ON ? RUN : IDLE;
            busy        <= START_ON;
            cfg_ready   <= 1'b1;
            half_reg    <= CNT_W'(DEFAULT_HALF);
            pend_half   <= '0;
            pend_enable <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        half_reg <= half_in;
                        if (cfg_enable) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        pend_half   <= half_in;
                        pend_enable <= cfg_enable;
                        state       <= PENDING;
                        cfg_ready   <= 1'b0;
                    end
                end
                PENDING: begin
                    // Swap only at the end of a high phase so no phase is cut short
                    if (fall) begin
                        half_reg  <= pend_half;
                        cfg_ready <= 1'b1;
                        busy      <= pend_enable;
                        state     <= pend_enable ? RUN : IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    clk_sched_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .half    (half_reg),
        .run     (busy),
        .clk_out (clk_out),
        .tick    (tick),
        .fall    (fall)
    );

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: expected clk_out edges are queued
// by the stimulus and matched by a monitor on every observed edge.
module tb_clk_div_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_half;
    logic        cfg_enable;
    logic        clk_out;
    logic        tick;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    typedef struct {
        int   c;
        logic lvl;
    } ev_t;

    ev_t exp_q[$];

    clk_div_sched dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_half   (cfg_half),
        .cfg_enable (cfg_enable),
        .clk_out    (clk_out),
        .tick       (tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input logic lvl);
        ev_t e;
        e.c   = c;
        e.lvl = lvl;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: any clk_out change or tick must match the queue head
    initial begin
        logic prev;
        ev_t  e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
            end else if (clk_out !== prev || tick) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_edge", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("edge_cycle", cyc, e.c);
                    chk("edge_level", int'(clk_out), int'(e.lvl));
                    chk("tick_on_rise", int'(tick), int'(clk_out && !prev));
                end
                prev = clk_out;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        cfg_valid  = 1'b0;
        cfg_half   = '0;
        cfg_enable = 1'b0;
        repeat (3) @(negedge clk);

        // Defaults: half 8, rises on edges 8, 24, 40
        push(8, 1'b1);  push(16, 1'b0);
        push(24, 1'b1); push(32, 1'b0);
        push(40, 1'b1); push(48, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_ready", int'(cfg_ready), 1);

        // Reconfigure to half 4 during the high phase 56..64
        wait_cyc(50);
        push(56, 1'b1); push(64, 1'b0);
        push(68, 1'b1); push(72, 1'b0);
        push(76, 1'b1); push(80, 1'b0);
        push(84, 1'b1); push(88, 1'b0);
        wait_cyc(58);
        chk("b_high_at_req", int'(clk_out), 1);
        cfg_valid  = 1'b1;
        cfg_half   = 16'd4;
        cfg_enable = 1'b1;
        wait_cyc(59);
        chk("b_ready_pend", int'(cfg_ready), 0);
        chk("b_busy_pend", int'(busy), 1);
        // Second request while pending must be dropped
        cfg_half = 16'd3;
        wait_cyc(62);
        cfg_valid = 1'b0;
        wait_cyc(63);
        chk("b_ready_still0", int'(cfg_ready), 0);
        wait_cyc(64);
        chk("b_ready_after", int'(cfg_ready), 1);

        // Stop request in the low phase 88..92
        wait_cyc(89);
        push(92, 1'b1); push(96, 1'b0);
        cfg_valid  = 1'b1;
        cfg_half   = 16'd5;
        cfg_enable = 1'b0;
        wait_cyc(90);
        cfg_valid = 1'b0;
        chk("c_ready_pend", int'(cfg_ready), 0);
        wait_cyc(95);
        chk("c_busy_before", int'(busy), 1);
        chk("c_clk_high", int'(clk_out), 1);
        wait_cyc(96);
        chk("c_busy_fall", int'(busy), 0);
        chk("c_clk_fall", int'(clk_out), 0);
        chk("c_ready_idle", int'(cfg_ready), 1);

        // From IDLE: half 0 acts as 1, period 2
        wait_cyc(110);
        chk("e_idle_clk", int'(clk_out), 0);
        chk("e_idle_tick", int'(tick), 0);
        chk("e_idle_busy", int'(busy), 0);
        for (int k = 112; k <= 124; k++) push(k, (k % 2) == 0);
        cfg_valid  = 1'b1;
        cfg_half   = 16'd0;
        cfg_enable = 1'b1;
        wait_cyc(111);
        cfg_valid = 1'b0;
        chk("e_busy_run", int'(busy), 1);

        // Asynchronous reset mid-high phase
        wait_cyc(124);
        chk("f_high_before", int'(clk_out), 1);
        #2 reset = 1'b1;
        #1;
        chk("f_rst_clk", int'(clk_out), 0);
        chk("f_rst_tick", int'(tick), 0);
        chk("f_rst_busy", int'(busy), 1);
        chk("f_rst_ready", int'(cfg_ready), 1);
        chk("f_q_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        push(8, 1'b1);  push(16, 1'b0);
        push(24, 1'b1); push(32, 1'b0);
        reset = 1'b0;
        wait_cyc(33);
        chk("end_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_sched.md
CLK_DIV_SCHED -- requirements
Module: clk_div_sched

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, the width of the half-period counter and of the configuration value.
REQ-002 The block SHALL have parameter DEFAULT_HALF, default 8, the half-period in clk cycles after reset (6.25 MHz output from 100 MHz).
REQ-003 The block SHALL have parameter START_ON, default 1, which when 1 makes the block run after reset and when 0 makes it idle.
REQ-004 The block SHALL have port clk  input  1  system clock (100 MHz), sole clock domain.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port cfg_valid  input  1  configuration request.
REQ-007 The block SHALL have port cfg_ready  output  1  configuration can be accepted this cycle.
REQ-008 The block SHALL have port cfg_half  input  CNT_W  requested half-period in clk cycles.
REQ-009 The block SHALL have port cfg_enable  input  1  requested run (1) or stop (0).
REQ-010 The block SHALL have port clk_out  output  1  registered divided clock, 50% duty.
REQ-011 The block SHALL have port tick  output  1  one-cycle pulse coincident with each 0->1 transition of clk_out.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and PENDING.
REQ-014 In RUN and PENDING, the counter SHALL count 0..half_reg-1 and, on the cycle where it equals half_reg-1, wrap to 0 and toggle clk_out.
REQ-015 tick SHALL be registered high on exactly the edge where clk_out goes 0->1, and low otherwise.
REQ-016 A configuration SHALL be accepted only when cfg_valid and cfg_ready are both high.
REQ-017 cfg_ready SHALL be 1 in IDLE and RUN and 0 in PENDING; requests made in PENDING are ignored and are not queued.
REQ-018 A cfg_half value of 0 SHALL be treated as 1 (clk/2 output); all other values SHALL be used unchanged.
REQ-019 An accept in IDLE SHALL load half_reg immediately; if cfg_enable=1 the block enters RUN with counter=0 and clk_out=0, otherwise it stays in IDLE.
REQ-020 An accept in RUN SHALL store pend_half and pend_enable and move the block to PENDING, leaving the current half_reg unchanged.
REQ-021 In PENDING, on the edge where clk_out toggles 1->0, half_reg SHALL take pend_half and the block SHALL enter RUN if pend_enable=1, or IDLE if pend_enable=0.
REQ-022 If clk_out is 0 when a request is accepted, the change SHALL wait for the end of the following high phase; there SHALL be no truncated phases and no glitches.
REQ-023 If an accept coincides with a 1->0 toggle, the change SHALL apply at the next 1->0 toggle, not the current one.
REQ-024 In IDLE, clk_out SHALL be 0, tick SHALL be 0 and the counter SHALL be held at 0.
REQ-025 busy SHALL fall on the same edge on which clk_out falls when stopping.

Reset
REQ-026 Reset assertion SHALL immediately force clk_out=0, tick=0 and counter=0.
REQ-027 Reset assertion SHALL immediately force half_reg=DEFAULT_HALF and clear pend_half and pend_enable.
REQ-028 Reset assertion SHALL immediately force the state to RUN if START_ON=1, else IDLE.
REQ-029 On reset, cfg_ready SHALL follow the reset state and any in-flight pending change SHALL be discarded.
REQ-030 The first clk_out rise after reset release with defaults SHALL occur on the 8th rising clk edge.

Structure
REQ-031 The state enum, CNT_W and DEFAULT_HALF SHALL live in the shared package clk_sched_pkg.
REQ-032 The counter-and-toggle datapath SHALL be one sub-module, clk_sched_counter (inputs: half, run; outputs: clk_out, tick, fall).
REQ-033 The FSM and the configuration handshake SHALL stay in the top level.

Verification
REQ-034 The bench SHALL check: reset release with defaults -> clk_out period 16 cycles, tick on edges 8, 24, 40, busy=1, cfg_ready=1.
REQ-035 The bench SHALL check: accept cfg_half=4, cfg_enable=1 while clk_out=1 -> cfg_ready=0 until the fall, then low 4, high 4, period 8, with no short phase.
REQ-036 The bench SHALL check: accept cfg_enable=0 in RUN -> clk_out completes its high phase, falls, stays 0; busy=0 on the same edge; no further tick.
REQ-037 The bench SHALL check: in IDLE, accept cfg_half=0, cfg_enable=1 -> clk_out toggles every cycle (period 2), with tick every 2 cycles.
REQ-038 The bench SHALL check: a second cfg_valid in PENDING with cfg_half=3 -> it is ignored; the first value takes effect.
REQ-039 The bench SHALL check: reset asserted mid-high phase -> clk_out=0 and tick=0 with no clk edge, then the default 16-cycle period resumes.
